// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//   Packet-atomic round-robin arbiter. NUM_SRC AXI4-Stream slave sources share
//   one 64-bit AXI4-Stream master port. A granted source owns the master port
//   until the beat carrying its TLAST has transferred. Choosing the next owner
//   takes one idle cycle per packet.
//
// Parameters
//   NUM_SRC  number of slave sources (2..8)
//   SEL_W    width of GRANT and of the round-robin pointer (2**SEL_W >= NUM_SRC)
//   CNT_W    width of the completed-packet counter
//
// Ports
//   ACLK, ARESETN        clock (rising edge) and asynchronous active-low reset
//   S_AXIS_TDATA/TKEEP   packed per-source data/keep, source i at [i*64 +: 64]
//                        and [i*8 +: 8]
//   S_AXIS_TVALID/TLAST  per-source valid and end-of-packet
//   S_AXIS_TREADY        per-source ready, only the granted source sees ready
//   M_AXIS_*             muxed master stream towards the downstream IP
//   GRANT                index of the granted source, meaningful while BUSY=1
//   BUSY                 high while a packet is in flight
//   PKT_CNT              packets forwarded since reset, wraps
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [NUM_SRC*64-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*8-1:0]  S_AXIS_TKEEP,
  input  logic [NUM_SRC-1:0]    S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]    S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]    S_AXIS_TREADY,
  output logic [63:0]           M_AXIS_TDATA,
  output logic [7:0]            M_AXIS_TKEEP,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [SEL_W-1:0]      GRANT,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      PKT_CNT
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  // Sized copies of the source count so pointer arithmetic stays width-exact.
  localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W+1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] LAST_SRC    = SEL_W'(NUM_SRC - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [2*NUM_SRC-1:0] valid_dbl;
  logic [2*NUM_SRC-1:0] valid_shift;
  logic [NUM_SRC-1:0]   valid_rot;
  logic                 any_valid;
  logic [SEL_W-1:0]     win_off;
  logic [SEL_W:0]       win_sum;
  logic [SEL_W-1:0]     winner;

  logic        sel_valid;
  logic        sel_last;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        beat_xfer;

  // Round-robin search: rotate the valid vector so bit 0 is the source at
  // ptr, take the lowest set bit, then map the offset back to a source index.
  // Doubling the vector makes the rotation a plain shift.
  always_comb begin
    valid_dbl   = {S_AXIS_TVALID, S_AXIS_TVALID};
    valid_shift = valid_dbl >> ptr_q;
    valid_rot   = valid_shift[NUM_SRC-1:0];
    any_valid   = |valid_rot;
    win_off     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        win_off = SEL_W'(i);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= NUM_SRC_EXT) begin
      win_sum = win_sum - NUM_SRC_EXT;
    end
    winner = win_sum[SEL_W-1:0];
  end

  // Data-path mux from the granted source. Selection by comparison keeps any
  // out-of-range grant value harmless instead of indexing past the vectors.
  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    S_AXIS_TREADY = '0;
    if (state_q == ST_PKT) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == SEL_W'(i)) begin
          sel_valid        = S_AXIS_TVALID[i];
          sel_last         = S_AXIS_TLAST[i];
          sel_data         = S_AXIS_TDATA[i*64 +: 64];
          sel_keep         = S_AXIS_TKEEP[i*8 +: 8];
          S_AXIS_TREADY[i] = M_AXIS_TREADY;
        end
      end
    end
    M_AXIS_TVALID = sel_valid;
    M_AXIS_TLAST  = sel_last;
    M_AXIS_TDATA  = sel_data;
    M_AXIS_TKEEP  = sel_keep;
    beat_xfer     = sel_valid & M_AXIS_TREADY;
  end

  // Next-state logic. A packet ends only on a transferred TLAST beat; a source
  // that drops TVALID mid-packet simply stalls while keeping its grant. The
  // pointer moves past the finished source so it becomes lowest priority.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_PKT;
          grant_d = winner;
        end
      end
      ST_PKT: begin
        if (beat_xfer && sel_last) begin
          state_d   = ST_IDLE;
          ptr_d     = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
          pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign GRANT   = grant_q;
  assign BUSY    = (state_q == ST_PKT);
  assign PKT_CNT = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
//   Directed bench for axis_rr_arbiter with two sources and a 2-bit packet
//   counter. Each source has its own driver fed from a beat queue; every beat
//   issued also goes into an expected-output queue in the order the arbiter
//   should forward it. A monitor compares every presented master beat, the
//   grant and the packet counter against that queue.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int NUM_SRC = 2;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  stall;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [2:0]  src;
  } exp_t;

  logic                  ACLK;
  logic                  ARESETN;
  logic [NUM_SRC*64-1:0] S_AXIS_TDATA;
  logic [NUM_SRC*8-1:0]  S_AXIS_TKEEP;
  logic [NUM_SRC-1:0]    S_AXIS_TVALID;
  logic [NUM_SRC-1:0]    S_AXIS_TLAST;
  logic [NUM_SRC-1:0]    S_AXIS_TREADY;
  logic [63:0]           M_AXIS_TDATA;
  logic [7:0]            M_AXIS_TKEEP;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;
  logic [SEL_W-1:0]      GRANT;
  logic                  BUSY;
  logic [CNT_W-1:0]      PKT_CNT;

  logic [63:0] s0_data, s1_data;
  logic [7:0]  s0_keep, s1_keep;
  logic        s0_valid, s1_valid;
  logic        s0_last, s1_last;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];

  int tests_run = 0;
  int failures  = 0;

  logic [CNT_W-1:0] exp_cnt;
  logic             cnt_pend;

  assign S_AXIS_TDATA  = {s1_data, s0_data};
  assign S_AXIS_TKEEP  = {s1_keep, s0_keep};
  assign S_AXIS_TVALID = {s1_valid, s0_valid};
  assign S_AXIS_TLAST  = {s1_last, s0_last};

  axis_rr_arbiter #(
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TKEEP (S_AXIS_TKEEP),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TKEEP (M_AXIS_TKEEP),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .GRANT        (GRANT),
    .BUSY         (BUSY),
    .PKT_CNT      (PKT_CNT)
  );

  // 10 ns clock.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one beat: queue it to its source driver and record the expected
  // master-side beat. Calls must follow the order the arbiter should emit.
  task automatic applyStimulus(input int src, input logic [63:0] data, input logic [7:0] keep,
                               input logic last, input logic [7:0] stall);
    beat_t b;
    exp_t  e;
    b.data = data; b.keep = keep; b.last = last; b.stall = stall;
    e.data = data; e.keep = keep; e.last = last; e.src = 3'(src);
    if (src == 0) q0.push_back(b);
    else          q1.push_back(b);
    exp_q.push_back(e);
  endtask

  // Wait until every issued beat has been forwarded and the arbiter is idle.
  task automatic waitDrain(input int budget, input string name);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
             !BUSY && !s0_valid && !s1_valid) && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    tests_run++;
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL %s drain timeout: %0d beats still expected, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic waitBusy(input int budget, input string name);
    int n;
    n = 0;
    while (!BUSY && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    tests_run++;
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL %s busy timeout: BUSY=%0b, expected 1", name, BUSY);
    end
  endtask

  // Source 0 driver: presents queued beats, holds each until the handshake.
  initial begin
    beat_t b;
    s0_valid = 1'b0; s0_data = '0; s0_keep = '0; s0_last = 1'b0;
    forever begin
      if (q0.size() == 0) begin
        s0_valid = 1'b0;
        @(posedge ACLK); #1;
      end else begin
        b = q0.pop_front();
        if (b.stall != 0) begin
          s0_valid = 1'b0;
          repeat (int'(b.stall)) begin @(posedge ACLK); #1; end
        end
        s0_data = b.data; s0_keep = b.keep; s0_last = b.last; s0_valid = 1'b1;
        do @(negedge ACLK); while (!S_AXIS_TREADY[0]);
        @(posedge ACLK); #1;
      end
    end
  end

  // Source 1 driver.
  initial begin
    beat_t b;
    s1_valid = 1'b0; s1_data = '0; s1_keep = '0; s1_last = 1'b0;
    forever begin
      if (q1.size() == 0) begin
        s1_valid = 1'b0;
        @(posedge ACLK); #1;
      end else begin
        b = q1.pop_front();
        if (b.stall != 0) begin
          s1_valid = 1'b0;
          repeat (int'(b.stall)) begin @(posedge ACLK); #1; end
        end
        s1_data = b.data; s1_keep = b.keep; s1_last = b.last; s1_valid = 1'b1;
        do @(negedge ACLK); while (!S_AXIS_TREADY[1]);
        @(posedge ACLK); #1;
      end
    end
  end

  // Monitor: every presented master beat must match the head of the expected
  // queue (held beats included), the grant must name the head's source, and
  // the cycle after a TLAST transfer must be idle with the counter advanced.
  initial begin
    exp_t e;
    exp_cnt  = '0;
    cnt_pend = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        exp_cnt  = '0;
        cnt_pend = 1'b0;
      end else begin
        if (cnt_pend) begin
          checkOutput("pkt_cnt", 64'(PKT_CNT), 64'(exp_cnt));
          checkOutput("idle_after_last", 64'(BUSY), 64'd0);
          cnt_pend = 1'b0;
        end
        if (BUSY && exp_q.size() > 0) begin
          checkOutput("grant", 64'(GRANT), 64'(exp_q[0].src));
        end
        if (M_AXIS_TVALID) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", M_AXIS_TDATA);
          end else begin
            e = exp_q[0];
            checkOutput("m_tdata", M_AXIS_TDATA, e.data);
            checkOutput("m_tkeep", 64'(M_AXIS_TKEEP), 64'(e.keep));
            checkOutput("m_tlast", 64'(M_AXIS_TLAST), 64'(e.last));
            if (M_AXIS_TREADY) begin
              void'(exp_q.pop_front());
              if (e.last) begin
                exp_cnt  = exp_cnt + 1'b1;
                cnt_pend = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    int n;
    logic [63:0] bp_data[4];
    logic        bp_rdy[4];

    ARESETN       = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (3) @(negedge ACLK);

    // Reset state.
    checkOutput("rst_busy",   64'(BUSY), 64'd0);
    checkOutput("rst_grant",  64'(GRANT), 64'd0);
    checkOutput("rst_pktcnt", 64'(PKT_CNT), 64'd0);
    checkOutput("rst_sready", 64'(S_AXIS_TREADY), 64'd0);
    checkOutput("rst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("rst_mdata",  M_AXIS_TDATA, 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;

    // Single source: BUSY rises one cycle after TVALID, three beats in order.
    $display("[TB] single source");
    applyStimulus(0, 64'h0000_0000_0000_0001, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'h0000_0000_0000_0002, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'h0000_0000_0000_0003, 8'hFF, 1'b1, 8'd0);
    n = 0;
    while (!s0_valid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("busy_with_first_valid", 64'(BUSY), 64'd0);
    @(negedge ACLK);
    checkOutput("busy_one_cycle_later", 64'(BUSY), 64'd1);
    checkOutput("single_grant", 64'(GRANT), 64'd0);
    waitDrain(50, "single");
    checkOutput("single_pktcnt", 64'(PKT_CNT), 64'd1);

    // Backpressure on a src1 packet: ready pattern 1,0,0,1.
    $display("[TB] backpressure");
    M_AXIS_TREADY = 1'b0;
    applyStimulus(1, 64'hFFEE_DDCC_BBAA_9988, 8'h01, 1'b0, 8'd0);
    applyStimulus(1, 64'hFFEE_DDCC_BBAA_9989, 8'h01, 1'b1, 8'd0);
    waitBusy(20, "backpressure");
    bp_rdy[0]  = 1'b1; bp_rdy[1]  = 1'b0; bp_rdy[2]  = 1'b0; bp_rdy[3]  = 1'b1;
    bp_data[0] = 64'hFFEE_DDCC_BBAA_9988;
    bp_data[1] = 64'hFFEE_DDCC_BBAA_9989;
    bp_data[2] = 64'hFFEE_DDCC_BBAA_9989;
    bp_data[3] = 64'hFFEE_DDCC_BBAA_9989;
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      M_AXIS_TREADY = bp_rdy[i];
      @(negedge ACLK);
      checkOutput("bp_sready", 64'(S_AXIS_TREADY), {62'd0, bp_rdy[i], 1'b0});
      checkOutput("bp_data", M_AXIS_TDATA, bp_data[i]);
      checkOutput("bp_keep", 64'(M_AXIS_TKEEP), 64'h01);
    end
    @(posedge ACLK); #1;
    M_AXIS_TREADY = 1'b1;
    waitDrain(50, "backpressure");

    // Contention with ptr at src0: src0, src1, src0, src1.
    $display("[TB] contention");
    applyStimulus(0, 64'hA0, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'hA1, 8'hFF, 1'b1, 8'd0);
    applyStimulus(1, 64'hB0, 8'hFF, 1'b0, 8'd0);
    applyStimulus(1, 64'hB1, 8'hFF, 1'b1, 8'd0);
    applyStimulus(0, 64'hC0, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'hC1, 8'hFF, 1'b1, 8'd0);
    applyStimulus(1, 64'hD0, 8'hFF, 1'b0, 8'd0);
    applyStimulus(1, 64'hD1, 8'hFF, 1'b1, 8'd0);
    waitDrain(100, "contention");

    // Reset mid-packet with downstream stalled.
    $display("[TB] reset mid-packet");
    M_AXIS_TREADY = 1'b0;
    applyStimulus(0, 64'h70, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'h71, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'h72, 8'hFF, 1'b1, 8'd0);
    waitBusy(20, "reset_mid");
    @(negedge ACLK);
    checkOutput("pre_reset_pktcnt", 64'(PKT_CNT), 64'd2);
    checkOutput("pre_reset_mvalid", 64'(M_AXIS_TVALID), 64'd1);
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    checkOutput("arst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("arst_sready", 64'(S_AXIS_TREADY), 64'd0);
    checkOutput("arst_busy",   64'(BUSY), 64'd0);
    checkOutput("arst_pktcnt", 64'(PKT_CNT), 64'd0);
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESETN       = 1'b1;
    M_AXIS_TREADY = 1'b1;
    waitBusy(20, "after_reset");
    checkOutput("after_reset_grant", 64'(GRANT), 64'd0);
    waitDrain(50, "after_reset");

    // Source stall: src0 drops valid for 4 cycles, src1 waits its turn.
    $display("[TB] source stall");
    applyStimulus(0, 64'h50, 8'hFF, 1'b0, 8'd0);
    applyStimulus(0, 64'h51, 8'hFF, 1'b0, 8'd4);
    applyStimulus(0, 64'h52, 8'hFF, 1'b1, 8'd0);
    waitBusy(20, "stall");
    applyStimulus(1, 64'h58, 8'h0F, 1'b0, 8'd0);
    applyStimulus(1, 64'h59, 8'h0F, 1'b1, 8'd0);
    repeat (3) @(negedge ACLK);
    checkOutput("stall_grant", 64'(GRANT), 64'd0);
    checkOutput("stall_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("stall_s1ready", 64'(S_AXIS_TREADY[1]), 64'd0);
    waitDrain(100, "stall");

    // Counter wrap: fresh reset, five single-beat packets -> 1,2,3,0,1.
    $display("[TB] counter wrap");
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 64'h60 + 64'(i), 8'hFF, 1'b1, 8'd0);
    end
    waitDrain(100, "wrap");
    checkOutput("wrap_final_pktcnt", 64'(PKT_CNT), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  // Hard backstop in case a drain loop never returns control.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
